// File: rtl/wb_stage_if.sv
// Memory-stage -> write-back stage bundle: handshake, instruction fields,
// RAM read data, register-file write port, decode bypass and debug trace.
interface wb_stage_if;
    logic        ms_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic        ms_res_from_mem;
    logic [2:0]  ms_mem_op;
    logic [1:0]  ms_addr_lo;
    logic [31:0] ms_alu_result;
    logic [31:0] data_sram_rdata;
    logic        wb_stall;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic        ws_fwd_valid;
    logic [4:0]  ws_fwd_dest;
    logic [31:0] ws_fwd_data;

    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    // Driver side: memory stage, RAM and register file / trace consumers.
    modport master (
        output ms_valid, ms_pc, ms_gr_we, ms_dest, ms_res_from_mem,
               ms_mem_op, ms_addr_lo, ms_alu_result, data_sram_rdata, wb_stall,
        input  ws_allowin, rf_we, rf_waddr, rf_wdata,
               ws_fwd_valid, ws_fwd_dest, ws_fwd_data,
               debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
    );

    // The write-back stage itself.
    modport slave (
        input  ms_valid, ms_pc, ms_gr_we, ms_dest, ms_res_from_mem,
               ms_mem_op, ms_addr_lo, ms_alu_result, data_sram_rdata, wb_stall,
        output ws_allowin, rf_we, rf_waddr, rf_wdata,
               ws_fwd_valid, ws_fwd_dest, ws_fwd_data,
               debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: one-entry pipeline register, load alignment/extension,
// register-file write port, decode bypass and debug trace.
module wb_stage (
    input  logic     clk,
    input  logic     resetn,
    wb_stage_if.slave bus
);
    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic        res_from_mem;
        logic [2:0]  mem_op;
        logic [1:0]  addr_lo;
        logic [31:0] alu_result;
    } ws_fields_t;

    logic       ws_valid_q, ws_valid_d;
    ws_fields_t fld_q, fld_d;
    logic       ws_ready_go;
    logic       ws_allowin;
    logic       wr_en;

    logic [3:0][7:0]  rd_bytes;
    logic [1:0][15:0] rd_halves;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic [31:0]      load_data;
    logic [31:0]      final_result;

    assign ws_ready_go = !bus.wb_stall;
    assign ws_allowin  = !ws_valid_q || ws_ready_go;

    always_comb begin
        ws_valid_d = ws_valid_q;
        fld_d      = fld_q;
        if (ws_allowin) begin
            ws_valid_d = bus.ms_valid;
        end
        if (bus.ms_valid && ws_allowin) begin
            fld_d.pc           = bus.ms_pc;
            fld_d.gr_we        = bus.ms_gr_we;
            fld_d.dest         = bus.ms_dest;
            fld_d.res_from_mem = bus.ms_res_from_mem;
            fld_d.mem_op       = bus.ms_mem_op;
            fld_d.addr_lo      = bus.ms_addr_lo;
            fld_d.alu_result   = bus.ms_alu_result;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid_q <= 1'b0;
            fld_q      <= '0;
        end else begin
            ws_valid_q <= ws_valid_d;
            fld_q      <= fld_d;
        end
    end

    // RAM word is consumed combinationally; the RAM holds it across a stall.
    assign rd_bytes  = bus.data_sram_rdata;
    assign rd_halves = bus.data_sram_rdata;
    assign sel_byte  = rd_bytes[fld_q.addr_lo];
    assign sel_half  = rd_halves[fld_q.addr_lo[1]];

    always_comb begin
        load_data = bus.data_sram_rdata;
        unique case (fld_q.mem_op)
            OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            OP_LBU:  load_data = {24'd0, sel_byte};
            OP_LHU:  load_data = {16'd0, sel_half};
            default: load_data = bus.data_sram_rdata;
        endcase
    end

    assign final_result = fld_q.res_from_mem ? load_data : fld_q.alu_result;

    // r0 is hard-wired zero: never written, never forwarded.
    assign wr_en = ws_valid_q && fld_q.gr_we && (fld_q.dest != 5'd0);

    assign bus.ws_allowin = ws_allowin;

    assign bus.rf_we    = wr_en && ws_ready_go;
    assign bus.rf_waddr = fld_q.dest;
    assign bus.rf_wdata = final_result;

    // Bypass ignores stall so decode sees the pending value while WB is held.
    assign bus.ws_fwd_valid = wr_en;
    assign bus.ws_fwd_dest  = fld_q.dest;
    assign bus.ws_fwd_data  = final_result;

    assign bus.debug_wb_pc       = fld_q.pc;
    assign bus.debug_wb_rf_we    = {4{wr_en && ws_ready_go}};
    assign bus.debug_wb_rf_wnum  = fld_q.dest;
    assign bus.debug_wb_rf_wdata = final_result;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected writes are queued on drive and
// popped when the register-file write port fires.
module tb_wb_stage;
    logic clk;
    logic resetn;

    wb_stage_if bus ();

    wb_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
        logic [31:0] pc;
    } wr_t;

    wr_t exp_q[$];
    int  n_assert;
    int  n_fail;
    int  n_writes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop for any write seen this cycle.
    task automatic mon();
        wr_t e;
        if (bus.rf_we === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                chk("sb_spurious_write", 32'(bus.rf_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_waddr", 32'(bus.rf_waddr), 32'(e.dest));
                chk("sb_wdata", bus.rf_wdata, e.data);
                chk("sb_pc", bus.debug_wb_pc, e.pc);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic gwe,
                         input logic [4:0] dest, input logic rfm, input logic [2:0] op,
                         input logic [1:0] lo, input logic [31:0] alu);
        bus.ms_valid        = v;
        bus.ms_pc           = pc;
        bus.ms_gr_we        = gwe;
        bus.ms_dest         = dest;
        bus.ms_res_from_mem = rfm;
        bus.ms_mem_op       = op;
        bus.ms_addr_lo      = lo;
        bus.ms_alu_result   = alu;
    endtask

    task automatic push(input logic [4:0] dest, input logic [31:0] data, input logic [31:0] pc);
        wr_t e;
        e.dest = dest;
        e.data = data;
        e.pc   = pc;
        exp_q.push_back(e);
    endtask

    logic [2:0]  ld_op  [6] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b010};
    logic [1:0]  ld_lo  [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    logic [31:0] ld_exp [6] = '{32'hFFFF_FF81, 32'h0000_0081, 32'h0000_007F,
                                32'hFFFF_80F0, 32'h0000_80F0, 32'h80F0_7F81};

    initial begin
        int w0;
        n_assert = 0;
        n_fail   = 0;
        n_writes = 0;
        resetn   = 1'b0;
        bus.wb_stall        = 1'b0;
        bus.data_sram_rdata = 32'h80F0_7F81;
        drive(1'b1, 32'h0000_0BAD, 1'b1, 5'd9, 1'b0, 3'b010, 2'd0, 32'hCAFE_F00D);

        // Reset held with ms_valid asserted
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_allowin", 32'(bus.ws_allowin), 32'd1);
        chk("rst_fwd_valid", 32'(bus.ws_fwd_valid), 32'd0);
        chk("rst_dbg_we", 32'(bus.debug_wb_rf_we), 32'd0);
        chk("rst_dbg_pc", bus.debug_wb_pc, 32'd0);
        chk("rst_dbg_wnum", 32'(bus.debug_wb_rf_wnum), 32'd0);
        chk("rst_dbg_wdata", bus.debug_wb_rf_wdata, 32'd0);
        @(negedge clk);
        bus.ms_valid = 1'b0;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_no_write", 32'(bus.rf_we), 32'd0);

        // ALU writeback
        drive(1'b1, 32'h0000_1000, 1'b1, 5'd5, 1'b0, 3'b010, 2'd0, 32'h1234_5678);
        push(5'd5, 32'h1234_5678, 32'h0000_1000);
        tick();
        bus.ms_valid = 1'b0;
        chk("alu_rf_we", 32'(bus.rf_we), 32'd1);
        chk("alu_waddr", 32'(bus.rf_waddr), 32'd5);
        chk("alu_wdata", bus.rf_wdata, 32'h1234_5678);
        chk("alu_fwd_valid", 32'(bus.ws_fwd_valid), 32'd1);
        chk("alu_dbg_we", 32'(bus.debug_wb_rf_we), 32'hF);
        tick();
        chk("alu_bubble", 32'(bus.rf_we), 32'd0);

        // Loads against a fixed RAM word
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h0000_2000 + 32'(i * 4), 1'b1, 5'(10 + i), 1'b1, ld_op[i], ld_lo[i], 32'hAAAA_AAAA);
            push(5'(10 + i), ld_exp[i], 32'h0000_2000 + 32'(i * 4));
            tick();
            bus.ms_valid = 1'b0;
            chk($sformatf("load%0d_wdata", i), bus.rf_wdata, ld_exp[i]);
            chk($sformatf("load%0d_fwd", i), bus.ws_fwd_data, ld_exp[i]);
            tick();
        end

        // Stall for three cycles holding dest 7; a competing instruction waits
        w0 = n_writes;
        drive(1'b1, 32'h0000_3000, 1'b1, 5'd7, 1'b0, 3'b010, 2'd0, 32'h0000_0777);
        push(5'd7, 32'h0000_0777, 32'h0000_3000);
        tick();
        bus.wb_stall = 1'b1;
        drive(1'b1, 32'h0000_3004, 1'b1, 5'd8, 1'b0, 3'b010, 2'd0, 32'h0000_0888);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d_allowin", i), 32'(bus.ws_allowin), 32'd0);
            chk($sformatf("stall%0d_rf_we", i), 32'(bus.rf_we), 32'd0);
            chk($sformatf("stall%0d_fwd_valid", i), 32'(bus.ws_fwd_valid), 32'd1);
            chk($sformatf("stall%0d_fwd_dest", i), 32'(bus.ws_fwd_dest), 32'd7);
            chk($sformatf("stall%0d_fwd_data", i), bus.ws_fwd_data, 32'h0000_0777);
            tick();
        end
        bus.wb_stall = 1'b0;
        bus.ms_valid = 1'b0;
        #1;
        chk("unstall_rf_we", 32'(bus.rf_we), 32'd1);
        chk("unstall_waddr", 32'(bus.rf_waddr), 32'd7);
        tick();
        chk("unstall_empty", 32'(bus.ws_fwd_valid), 32'd0);
        chk("stall_one_write", 32'(n_writes - w0), 32'd1);

        // Destination 0 passes through without a write
        drive(1'b1, 32'h0000_4000, 1'b1, 5'd0, 1'b0, 3'b010, 2'd0, 32'hDEAD_BEEF);
        tick();
        bus.ms_valid = 1'b0;
        chk("r0_rf_we", 32'(bus.rf_we), 32'd0);
        chk("r0_fwd_valid", 32'(bus.ws_fwd_valid), 32'd0);
        chk("r0_dbg_we", 32'(bus.debug_wb_rf_we), 32'd0);
        chk("r0_dbg_wdata", bus.debug_wb_rf_wdata, 32'hDEAD_BEEF);
        chk("r0_dbg_pc", bus.debug_wb_pc, 32'h0000_4000);
        tick();

        // Back-to-back dest 1,2,3
        w0 = n_writes;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 32'h0000_5000 + 32'(i * 4), 1'b1, 5'(i), 1'b0, 3'b010, 2'd0, 32'h0000_0100 + 32'(i));
            push(5'(i), 32'h0000_0100 + 32'(i), 32'h0000_5000 + 32'(i * 4));
            tick();
            chk($sformatf("b2b%0d_rf_we", i), 32'(bus.rf_we), 32'd1);
            chk($sformatf("b2b%0d_waddr", i), 32'(bus.rf_waddr), 32'(i));
        end
        bus.ms_valid = 1'b0;
        tick();
        chk("b2b_write_count", 32'(n_writes - w0), 32'd3);

        // Reset during a stall discards the held instruction
        drive(1'b1, 32'h0000_6000, 1'b1, 5'd20, 1'b0, 3'b010, 2'd0, 32'h0000_6666);
        tick();
        bus.ms_valid = 1'b0;
        bus.wb_stall = 1'b1;
        tick();
        resetn = 1'b0;
        #1;
        chk("rst_mid_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_mid_fwd", 32'(bus.ws_fwd_valid), 32'd0);
        chk("rst_mid_allowin", 32'(bus.ws_allowin), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        bus.wb_stall = 1'b0;
        @(posedge clk);
        #1;
        tick();
        chk("rst_mid_no_write", 32'(bus.rf_we), 32'd0);
        tick();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
